// File: rtl/rv_decode_pkg.sv
// rtl/rv_decode_pkg.sv - RV32I opcode, immediate-select and ID/EX register definitions
package rv_decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b101;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  imm_sel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic        illegal;
  } id_ex_t;

  localparam id_ex_t ID_EX_RESET = '{
    imm:     32'd0,
    imm_sel: IMM_NONE,
    rs1:     5'd0,
    rs2:     5'd0,
    rd:      5'd0,
    opcode:  7'd0,
    funct3:  3'd0,
    funct7:  7'd0,
    pc:      32'd0,
    illegal: 1'b0
  };

endpackage

// File: rtl/immGen.sv
// rtl/immGen.sv - sign-extended RV32I immediate generator selected by format code
module immGen
  import rv_decode_pkg::*;
#(
  parameter int width = 32
) (
  input  logic [width-1:0] instr,
  input  logic [2:0]       immSel,
  output logic [width-1:0] imm
);

  logic unused_opcode_bits;
  assign unused_opcode_bits = ^instr[6:0];

  always_comb begin
    imm = '0;
    case (immSel)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'd0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/opcode_class.sv
// rtl/opcode_class.sv - opcode to immediate format and register-usage classification
module opcode_class
  import rv_decode_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] imm_sel_o,
  output logic       use_rs1_o,
  output logic       use_rs2_o,
  output logic       use_rd_o,
  output logic       illegal_o
);

  always_comb begin
    imm_sel_o = IMM_NONE;
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    use_rd_o  = 1'b0;
    illegal_o = 1'b0;
    unique case (opcode_i)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE: begin
        imm_sel_o = IMM_I;
        use_rs1_o = 1'b1;
        use_rd_o  = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        imm_sel_o = (opcode_i == OP_STORE) ? IMM_S : IMM_B;
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm_sel_o = IMM_U;
        use_rd_o  = 1'b1;
      end
      OP_JAL: begin
        imm_sel_o = IMM_J;
        use_rd_o  = 1'b1;
      end
      OP_REG: begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
        use_rd_o  = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
    // Compressed-encoding low bits never match a base opcode, kept explicit for clarity
    if (opcode_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
      imm_sel_o = IMM_NONE;
      use_rs1_o = 1'b0;
      use_rs2_o = 1'b0;
      use_rd_o  = 1'b0;
    end
  end

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered RV32I decode stage feeding the ID/EX pipeline register
module imm_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_instr,
  input  logic [width-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_imm,
  output logic [2:0]       out_imm_sel,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [width-1:0] out_pc,
  output logic             out_illegal,
  output logic [31:0]      decode_count
);

  logic [2:0]       imm_sel;
  logic             use_rs1;
  logic             use_rs2;
  logic             use_rd;
  logic             illegal;
  logic [width-1:0] imm;
  logic             load;

  id_ex_t      held_q, held_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  opcode_class u_class (
    .opcode_i  (in_instr[6:0]),
    .imm_sel_o (imm_sel),
    .use_rs1_o (use_rs1),
    .use_rs2_o (use_rs2),
    .use_rd_o  (use_rd),
    .illegal_o (illegal)
  );

  immGen #(.width(width)) u_imm_gen (
    .instr  (in_instr),
    .immSel (imm_sel),
    .imm    (imm)
  );

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    held_d = held_q;
    if (load) begin
      held_d.imm     = imm;
      held_d.imm_sel = imm_sel;
      held_d.rs1     = use_rs1 ? in_instr[19:15] : 5'd0;
      held_d.rs2     = use_rs2 ? in_instr[24:20] : 5'd0;
      held_d.rd      = use_rd  ? in_instr[11:7]  : 5'd0;
      held_d.opcode  = in_instr[6:0];
      held_d.funct3  = in_instr[14:12];
      held_d.funct7  = in_instr[31:25];
      held_d.pc      = in_pc;
      held_d.illegal = illegal;
    end
  end

  // Flush outranks load so a redirect also kills the instruction arriving this cycle
  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (load)      valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  always_comb begin
    count_d = count_q;
    if (valid_q && out_ready && !flush) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q  <= ID_EX_RESET;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      held_q  <= held_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_imm      = held_q.imm;
  assign out_imm_sel  = held_q.imm_sel;
  assign out_rs1      = held_q.rs1;
  assign out_rs2      = held_q.rs2;
  assign out_rd       = held_q.rd;
  assign out_opcode   = held_q.opcode;
  assign out_funct3   = held_q.funct3;
  assign out_funct7   = held_q.funct7;
  assign out_pc       = held_q.pc;
  assign out_illegal  = held_q.illegal;
  assign decode_count = count_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - self-checking bench for imm_decode_stage
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm, out_pc, decode_count;
  logic [2:0]  out_imm_sel, out_funct3;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [6:0]  out_opcode, out_funct7;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.width(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_imm_sel(out_imm_sel),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_pc(out_pc), .out_illegal(out_illegal), .decode_count(decode_count)
  );

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  sel;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;

  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [6:0]  op;
    logic [31:0] sx;
    logic        r1, r2, rdu;
    op  = ins[6:0];
    sx  = ins[31] ? 32'hFFFFF000 : 32'h0;
    r1  = 1'b0; r2 = 1'b0; rdu = 1'b0;
    e.imm = 32'h0;
    e.sel = 3'd5;
    e.illegal = 1'b0;
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        e.sel = 3'd0; r1 = 1'b1; rdu = 1'b1;
        e.imm = sx | {20'd0, ins[31:20]};
      end
      7'b0100011: begin
        e.sel = 3'd1; r1 = 1'b1; r2 = 1'b1;
        e.imm = sx | {20'd0, ins[31:25], 5'd0} | {27'd0, ins[11:7]};
      end
      7'b1100011: begin
        e.sel = 3'd2; r1 = 1'b1; r2 = 1'b1;
        e.imm = sx | ({31'd0, ins[7]} << 11) | ({26'd0, ins[30:25]} << 5) | ({28'd0, ins[11:8]} << 1);
      end
      7'b0110111, 7'b0010111: begin
        e.sel = 3'd3; rdu = 1'b1;
        e.imm = ins & 32'hFFFFF000;
      end
      7'b1101111: begin
        e.sel = 3'd4; rdu = 1'b1;
        e.imm = (ins[31] ? 32'hFFF00000 : 32'h0) | ({24'd0, ins[19:12]} << 12)
              | ({31'd0, ins[20]} << 11) | ({22'd0, ins[30:21]} << 1);
      end
      7'b0110011: begin
        r1 = 1'b1; r2 = 1'b1; rdu = 1'b1;
      end
      default: e.illegal = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) e.illegal = 1'b1;
    if (e.illegal) begin
      e.sel = 3'd5; e.imm = 32'h0; r1 = 1'b0; r2 = 1'b0; rdu = 1'b0;
    end
    e.rs1    = r1  ? ins[19:15] : 5'd0;
    e.rs2    = r2  ? ins[24:20] : 5'd0;
    e.rd     = rdu ? ins[11:7]  : 5'd0;
    e.opcode = op;
    e.funct3 = ins[14:12];
    e.funct7 = ins[31:25];
    e.pc     = pc;
    return e;
  endfunction

  exp_t        m_f;
  logic        m_valid;
  logic [31:0] m_count;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0;
      m_count = 32'd0;
      m_f = '{imm: 32'd0, sel: 3'd5, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
              opcode: 7'd0, funct7: 7'd0, funct3: 3'd0, pc: 32'd0, illegal: 1'b0};
    end else begin
      if (m_valid && out_ready && !flush) m_count = m_count + 32'd1;
      if (flush) begin
        m_valid = 1'b0;
      end else if (in_valid && (!m_valid || out_ready)) begin
        m_f = model_decode(in_instr, in_pc);
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("m_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("m_count", decode_count, m_count);
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
      chk("m_imm", out_imm, m_f.imm);
      chk("m_sel", {29'd0, out_imm_sel}, {29'd0, m_f.sel});
      chk("m_rs1", {27'd0, out_rs1}, {27'd0, m_f.rs1});
      chk("m_rs2", {27'd0, out_rs2}, {27'd0, m_f.rs2});
      chk("m_rd", {27'd0, out_rd}, {27'd0, m_f.rd});
      chk("m_opcode", {25'd0, out_opcode}, {25'd0, m_f.opcode});
      chk("m_funct3", {29'd0, out_funct3}, {29'd0, m_f.funct3});
      chk("m_funct7", {25'd0, out_funct7}, {25'd0, m_f.funct7});
      chk("m_pc", out_pc, m_f.pc);
      chk("m_illegal", {31'd0, out_illegal}, {31'd0, m_f.illegal});
    end
  end

  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string tag, input logic [31:0] imm, input logic [2:0] sel,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_imm"}, out_imm, imm);
    chk({tag, "_sel"}, {29'd0, out_imm_sel}, {29'd0, sel});
    chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
    chk({tag, "_rs1"}, {27'd0, out_rs1}, {27'd0, rs1});
    chk({tag, "_rs2"}, {27'd0, out_rs2}, {27'd0, rs2});
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_count"}, decode_count, cnt);
  endtask

  logic [31:0] tbl [8];

  initial begin
    tbl[0] = 32'h002081B3; tbl[1] = 32'h00412283; tbl[2] = 32'h000280E7; tbl[3] = 32'h00001397;
    tbl[4] = 32'h0FF0000F; tbl[5] = 32'h00000073; tbl[6] = 32'h40208133; tbl[7] = 32'h0000007F;

    reset = 1'b1;
    in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", decode_count, 32'd0);
    chk("rst_sel", {29'd0, out_imm_sel}, 32'd5);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    cyc(1, 32'hFFF00093, 32'h100, 1, 0);
    lit("addi", 32'hFFFFFFFF, 3'b000, 5'd1, 5'd0, 5'd0, 32'h100, 32'd0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("addi_cnt", decode_count, 32'd1);
    chk("addi_drain", {31'd0, out_valid}, 32'd0);

    cyc(1, 32'h0020A423, 32'h104, 1, 0);
    lit("sw", 32'd8, 3'b001, 5'd0, 5'd1, 5'd2, 32'h104, 32'd1);
    cyc(1, 32'hFE000EE3, 32'h108, 1, 0);
    lit("beq", 32'hFFFFFFFC, 3'b010, 5'd0, 5'd0, 5'd0, 32'h108, 32'd2);
    cyc(1, 32'h123452B7, 32'h10C, 1, 0);
    lit("lui", 32'h12345000, 3'b011, 5'd5, 5'd0, 5'd0, 32'h10C, 32'd3);
    cyc(1, 32'h001000EF, 32'h110, 1, 0);
    lit("jal", 32'h00000800, 3'b100, 5'd1, 5'd0, 5'd0, 32'h110, 32'd4);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("b2b_cnt", decode_count, 32'd5);

    cyc(1, 32'h002081B3, 32'h200, 0, 0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = 32'h00412283; in_pc = 32'h204; out_ready = 1'b0; flush = 1'b0;
      #1;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      lit("stall", 32'd0, 3'b101, 5'd3, 5'd1, 5'd2, 32'h200, 32'd5);
    end
    cyc(1, 32'h00412283, 32'h204, 1, 0);
    lit("unstall", 32'd4, 3'b000, 5'd5, 5'd2, 5'd0, 32'h204, 32'd6);

    cyc(1, 32'h001000EF, 32'h300, 1, 1);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_count", decode_count, 32'd6);
    chk("flush_pc_kept", out_pc, 32'h204);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("flush_after", {31'd0, out_valid}, 32'd0);
    cyc(1, 32'h001000EF, 32'h304, 1, 1);
    chk("flush_empty_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_empty_pc", out_pc, 32'h204);

    cyc(1, 32'h0000007F, 32'h400, 1, 0);
    lit("ill7f", 32'd0, 3'b101, 5'd0, 5'd0, 5'd0, 32'h400, 32'd6);
    chk("ill7f_flag", {31'd0, out_illegal}, 32'd1);
    cyc(1, 32'hFFF00090, 32'h404, 1, 0);
    lit("ill90", 32'd0, 3'b101, 5'd0, 5'd0, 5'd0, 32'h404, 32'd7);
    chk("ill90_flag", {31'd0, out_illegal}, 32'd1);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("ill_cnt", decode_count, 32'd8);

    cyc(1, 32'hFFF00093, 32'h500, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_count", decode_count, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #3 reset = 1'b0;
    cyc(1, 32'h0020A423, 32'h600, 1, 0);
    lit("post_rst", 32'd8, 3'b001, 5'd0, 5'd1, 5'd2, 32'h600, 32'd0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("post_rst_cnt", decode_count, 32'd1);

    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), tbl[$urandom_range(0, 7)], 32'h1000 + 32'(i * 4),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
    end
    cyc(0, 32'h0, 32'h0, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
